// File: rtl/dshot_rx_array.sv
// N-channel DShot receiver: per-channel pulse-width decoding, CRC check,
// throttle/command/telemetry separation and link-loss failsafe.
module dshot_rx_array #(
    parameter int CHANNELS       = 8,
    parameter int CLK_HZ         = 16000000,
    parameter int DSHOT_KBPS     = 150,
    parameter int OUT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 160000
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [CHANNELS-1:0]             dshotPins,
    output logic [CHANNELS*OUT_WIDTH-1:0]   speedFlat,
    output logic [CHANNELS*6-1:0]           cmdFlat,
    output logic [CHANNELS-1:0]             telemetryReq,
    output logic [CHANNELS-1:0]             linkValid,
    output logic [CHANNELS-1:0]             framePulse,
    output logic [CHANNELS-1:0]             cmdPulse,
    output logic [CHANNELS-1:0]             frameErr
);

    localparam int BIT_CYCLES = CLK_HZ / (DSHOT_KBPS * 1000);
    localparam int CNT_W      = $clog2(2 * BIT_CYCLES + 1);
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SHIFT      = 11 - OUT_WIDTH;

    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(2 * BIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic                 sync_meta_reg, sync_reg, prev_reg;
            state_t               state_reg;
            logic [CNT_W-1:0]     high_cnt_reg, low_cnt_reg;
            logic [4:0]           bit_cnt_reg;
            // Only the first 15 bits are stored; the 16th is consumed as it arrives.
            logic [14:0]          sr_reg;
            logic [TO_W-1:0]      to_cnt_reg;
            logic [OUT_WIDTH-1:0] speed_reg;
            logic [5:0]           cmd_reg;
            logic                 telem_reg, link_reg;
            logic                 frame_pulse_reg, cmd_pulse_reg, err_reg;

            logic                 rise, fall, bit_val, last_bit, frame_done, crc_ok, frame_valid;
            logic [15:0]          frame_next;
            logic [11:0]          v;
            logic [10:0]          thr, diff;
            logic [3:0]           crc_calc;
            logic [OUT_WIDTH-1:0] speed_val;

            assign rise        = sync_reg & ~prev_reg;
            assign fall        = ~sync_reg & prev_reg;
            assign bit_val     = (high_cnt_reg > HALF_BIT);
            assign frame_next  = {sr_reg, bit_val};
            assign last_bit    = (bit_cnt_reg == 5'd15);
            assign frame_done  = (state_reg == ST_HIGH) && fall && last_bit;
            assign v           = frame_next[15:4];
            assign crc_calc    = v[3:0] ^ v[7:4] ^ v[11:8];
            assign crc_ok      = (crc_calc == frame_next[3:0]);
            assign frame_valid = frame_done && crc_ok;
            assign thr         = v[11:1];
            assign diff        = thr - 11'd48;
            assign speed_val   = diff[10:SHIFT];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_meta_reg   <= 1'b0;
                    sync_reg        <= 1'b0;
                    prev_reg        <= 1'b0;
                    state_reg       <= ST_IDLE;
                    high_cnt_reg    <= '0;
                    low_cnt_reg     <= '0;
                    bit_cnt_reg     <= '0;
                    sr_reg          <= '0;
                    to_cnt_reg      <= '0;
                    speed_reg       <= '0;
                    cmd_reg         <= '0;
                    telem_reg       <= 1'b0;
                    link_reg        <= 1'b0;
                    frame_pulse_reg <= 1'b0;
                    cmd_pulse_reg   <= 1'b0;
                    err_reg         <= 1'b0;
                end else begin
                    sync_meta_reg   <= dshotPins[gi];
                    sync_reg        <= sync_meta_reg;
                    prev_reg        <= sync_reg;
                    frame_pulse_reg <= 1'b0;
                    cmd_pulse_reg   <= 1'b0;
                    err_reg         <= 1'b0;

                    case (state_reg)
                        ST_IDLE: begin
                            if (rise) begin
                                state_reg    <= ST_HIGH;
                                bit_cnt_reg  <= '0;
                                high_cnt_reg <= CNT_W'(1);
                            end
                        end
                        ST_HIGH: begin
                            if (fall) begin
                                sr_reg      <= frame_next[14:0];
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                                if (last_bit) begin
                                    state_reg <= ST_IDLE;
                                    err_reg   <= ~crc_ok;
                                end else begin
                                    state_reg   <= ST_LOW;
                                    low_cnt_reg <= CNT_W'(1);
                                end
                            end else if (high_cnt_reg == HIGH_LAST) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_IDLE;
                            end else begin
                                high_cnt_reg <= high_cnt_reg + CNT_W'(1);
                            end
                        end
                        ST_LOW: begin
                            // bit_cnt is always 1..15 here, so any long low is a broken frame.
                            if (rise) begin
                                state_reg    <= ST_HIGH;
                                high_cnt_reg <= CNT_W'(1);
                            end else if (low_cnt_reg == LOW_LAST) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_IDLE;
                            end else begin
                                low_cnt_reg <= low_cnt_reg + CNT_W'(1);
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase

                    // A valid frame takes priority over a timeout in the same cycle.
                    if (frame_valid) begin
                        frame_pulse_reg <= 1'b1;
                        telem_reg       <= v[0];
                        to_cnt_reg      <= '0;
                        link_reg        <= 1'b1;
                        if (thr == 11'd0) begin
                            speed_reg <= '0;
                        end else if (thr < 11'd48) begin
                            cmd_reg       <= thr[5:0];
                            cmd_pulse_reg <= 1'b1;
                        end else begin
                            speed_reg <= speed_val;
                        end
                    end else begin
                        if (to_cnt_reg != TO_MAX)
                            to_cnt_reg <= to_cnt_reg + TO_W'(1);
                        if (to_cnt_reg == TO_LAST) begin
                            link_reg  <= 1'b0;
                            speed_reg <= '0;
                        end
                    end
                end
            end

            assign speedFlat[(CHANNELS-gi)*OUT_WIDTH-1 -: OUT_WIDTH] = speed_reg;
            assign cmdFlat[(CHANNELS-gi)*6-1 -: 6]                 = cmd_reg;
            assign telemetryReq[gi] = telem_reg;
            assign linkValid[gi]    = link_reg;
            assign framePulse[gi]   = frame_pulse_reg;
            assign cmdPulse[gi]     = cmd_pulse_reg;
            assign frameErr[gi]     = err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dshot_rx_array.sv
// Scoreboard bench for dshot_rx_array: an 8-channel/8-bit instance and a
// 2-channel/11-bit instance, with a shortened failsafe timeout.
module tb_dshot_rx_array;

    localparam int TO = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [7:0]  pins_a;
    logic [1:0]  pins_b;
    logic [63:0] speed_a;
    logic [47:0] cmd_a;
    logic [7:0]  tel_a, link_a, fp_a, cp_a, fe_a;
    logic [21:0] speed_b;
    logic [11:0] cmd_b;
    logic [1:0]  tel_b, link_b, fp_b, cp_b, fe_b;

    dshot_rx_array #(.CHANNELS(8), .OUT_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut_a (
        .CLK(clk), .RST(rst_a), .dshotPins(pins_a), .speedFlat(speed_a), .cmdFlat(cmd_a),
        .telemetryReq(tel_a), .linkValid(link_a), .framePulse(fp_a), .cmdPulse(cp_a),
        .frameErr(fe_a)
    );

    dshot_rx_array #(.CHANNELS(2), .OUT_WIDTH(11), .TIMEOUT_CYCLES(TO)) dut_b (
        .CLK(clk), .RST(rst_b), .dshotPins(pins_b), .speedFlat(speed_b), .cmdFlat(cmd_b),
        .telemetryReq(tel_b), .linkValid(link_b), .framePulse(fp_b), .cmdPulse(cp_b),
        .frameErr(fe_b)
    );

    typedef struct {
        int ch;
        bit err;
        int speed;
        int cmd;
        bit tel;
        bit cpulse;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   m_speed [2][8];
    int   m_cmd   [2][8];
    bit   m_tel   [2][8];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc = 0;
    int   pulse_cyc [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference model: expected outcome of a frame given the channel history.
    task automatic push_exp(input int which, input int ch, input logic [15:0] w, input bit force_err);
        exp_t        e;
        logic [11:0] v;
        logic [11:0] c;
        int          thr;
        v = w[15:4];
        c = (v ^ (v >> 4) ^ (v >> 8)) & 12'hF;
        e.ch = ch;
        e.cpulse = 1'b0;
        if (force_err || c[3:0] != w[3:0]) begin
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            thr = int'(v >> 1);
            m_tel[which][ch] = v[0];
            if (thr == 0) m_speed[which][ch] = 0;
            else if (thr < 48) begin
                m_cmd[which][ch] = thr;
                e.cpulse = 1'b1;
            end else m_speed[which][ch] = (thr - 48) >> (which != 0 ? 0 : 3);
        end
        e.speed = m_speed[which][ch];
        e.cmd   = m_cmd[which][ch];
        e.tel   = m_tel[which][ch];
        if (which == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic score_evt(input int which, input int c, input bit err, input int spd,
                             input int cmd, input bit tel, input bit lnk, input bit cp);
        exp_t e;
        if ((which == 0 && q_a.size() == 0) || (which != 0 && q_b.size() == 0)) begin
            check_val("unexpected_event", c, -1);
            return;
        end
        e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
        check_val("evt_channel", c, e.ch);
        check_val("evt_is_err", err, e.err);
        check_val("evt_speed", spd, e.speed);
        check_val("evt_cmd", cmd, e.cmd);
        check_val("evt_telem", tel, e.tel);
        check_val("evt_cmd_pulse", cp, e.cpulse);
        if (!e.err) check_val("evt_link", lnk, 1);
        $display("dut%0d ch%0d %s speed=%0d cmd=%0d tel=%0d link=%0d", which, c,
                 err ? "frame_err" : "frame_ok", spd, cmd, tel, lnk);
    endtask

    always @(negedge clk) begin
        if (!rst_a)
            for (int c = 0; c < 8; c++)
                if (fp_a[c] | fe_a[c]) begin
                    if (fp_a[c]) pulse_cyc[c] = cyc;
                    score_evt(0, c, fe_a[c], int'(speed_a[(7-c)*8 +: 8]), int'(cmd_a[(7-c)*6 +: 6]),
                              tel_a[c], link_a[c], cp_a[c]);
                end
        if (!rst_b)
            for (int c = 0; c < 2; c++)
                if (fp_b[c] | fe_b[c])
                    score_evt(1, c, fe_b[c], int'(speed_b[(1-c)*11 +: 11]), int'(cmd_b[(1-c)*6 +: 6]),
                              tel_b[c], link_b[c], cp_b[c]);
    end

    function automatic bit evt(input int which, input int ch);
        if (which == 0) return fp_a[ch] | fe_a[ch];
        return fp_b[ch] | fe_b[ch];
    endfunction

    task automatic set_pin(input int which, input int ch, input bit val);
        if (which == 0) pins_a[ch] = val;
        else pins_b[ch] = val;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the top nbits of w, MSB first; a full frame also checks result latency.
    task automatic send_bits(input int which, input int ch, input logic [15:0] w, input int nbits);
        int h;
        for (int i = 15; i >= 16 - nbits; i--) begin
            h = w[i] ? 80 : 40;
            for (int k = 0; k < 106; k++) begin
                if (nbits == 16 && i == 0) begin
                    if (k == h + 2) check_val("latency_early", evt(which, ch), 0);
                    if (k == h + 3) check_val("latency_e_plus_1", evt(which, ch), 1);
                    if (k == h + 4) check_val("pulse_width", evt(which, ch), 0);
                end
                set_pin(which, ch, k < h);
                @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input int which, input int ch, input logic [15:0] w);
        push_exp(which, ch, w, 1'b0);
        send_bits(which, ch, w, 16);
        idle(10);
    endtask

    task automatic send_pair_b(input logic [15:0] w0, input logic [15:0] w1);
        push_exp(1, 0, w0, 1'b0);
        push_exp(1, 1, w1, 1'b0);
        for (int i = 15; i >= 0; i--)
            for (int k = 0; k < 106; k++) begin
                pins_b[0] = (k < (w0[i] ? 80 : 40));
                pins_b[1] = (k < (w1[i] ? 80 : 40));
                @(negedge clk);
            end
        idle(10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        pins_a = '0;
        pins_b = '0;
        idle(5);
        check_val("rst_speed_a", longint'(speed_a), 0);
        check_val("rst_cmd_a", longint'(cmd_a), 0);
        check_val("rst_flags_a", longint'({tel_a, link_a, fp_a, cp_a, fe_a}), 0);
        check_val("rst_all_b", longint'({speed_b, cmd_b, tel_b, link_b, fp_b, cp_b, fe_b}), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(5);
        check_val("post_rst_link_a", longint'(link_a), 0);

        // Throttle 1048 on channel 0
        send_frame(0, 0, 16'h830B);
        check_val("ch0_speed_125", longint'(speed_a[63:56]), 125);
        check_val("other_speeds_zero", longint'(speed_a[55:0]), 0);
        check_val("link_only_ch0", longint'(link_a), 1);

        // Bad CRC keeps the previous speed
        send_frame(0, 0, 16'h830A);
        check_val("bad_crc_speed_held", longint'(speed_a[63:56]), 125);

        // Partial frame followed by a long low, then a good frame
        push_exp(0, 0, 16'hAAAA, 1'b1);
        send_bits(0, 0, 16'hAAAA, 10);
        pins_a[0] = 1'b0;
        idle(250);
        send_frame(0, 0, 16'h830B);
        check_val("after_abort_speed", longint'(speed_a[63:56]), 125);

        // Line stuck high
        push_exp(0, 0, 16'h0000, 1'b1);
        pins_a[0] = 1'b1;
        idle(200);
        pins_a[0] = 1'b0;
        idle(20);

        // Command, full throttle and zero throttle on channel 3
        send_frame(0, 3, 16'h0154);
        check_val("ch3_cmd_10", longint'(cmd_a[(7-3)*6 +: 6]), 10);
        check_val("ch3_telem", longint'(tel_a[3]), 1);
        check_val("ch3_speed_unchanged", longint'(speed_a[(7-3)*8 +: 8]), 0);
        send_frame(0, 3, 16'hFFEE);
        check_val("ch3_speed_249", longint'(speed_a[(7-3)*8 +: 8]), 249);
        send_frame(0, 3, 16'h0000);
        check_val("ch3_speed_0", longint'(speed_a[(7-3)*8 +: 8]), 0);
        check_val("ch0_untouched", longint'(speed_a[63:56]), 125);

        // Failsafe timeout on channel 5
        send_frame(0, 5, 16'h830B);
        check_val("ch5_speed_before_to", longint'(speed_a[(7-5)*8 +: 8]), 125);
        for (int k = 0; k < TO + 3000; k++) begin
            @(negedge clk);
            if (!link_a[5]) break;
        end
        check_val("timeout_cycles", cyc - pulse_cyc[5], TO);
        check_val("timeout_link", longint'(link_a[5]), 0);
        check_val("timeout_speed", longint'(speed_a[(7-5)*8 +: 8]), 0);
        check_val("timeout_cmd_held", longint'(cmd_a[(7-3)*6 +: 6]), 10);
        for (int c = 0; c < 8; c++) m_speed[0][c] = 0;
        send_frame(0, 5, 16'h830B);
        check_val("restore_link", longint'(link_a[5]), 1);
        check_val("restore_speed", longint'(speed_a[(7-5)*8 +: 8]), 125);

        // Two channels at once, 11-bit output
        send_pair_b(16'hFFEE, 16'h830B);
        check_val("b_ch0_1999", longint'(speed_b[21:11]), 1999);
        check_val("b_ch1_1000", longint'(speed_b[10:0]), 1000);

        // Reset mid-frame
        send_bits(1, 0, 16'hFFEE, 5);
        pins_b[0] = 1'b1;
        idle(10);
        rst_b = 1'b1;
        #1;
        check_val("midrst_outputs_zero", longint'({speed_b, cmd_b, tel_b, link_b, fp_b, cp_b, fe_b}), 0);
        pins_b = '0;
        idle(5);
        rst_b = 1'b0;
        idle(5);
        check_val("post_midrst_zero", longint'({speed_b, link_b}), 0);
        for (int c = 0; c < 2; c++) begin
            m_speed[1][c] = 0;
            m_cmd[1][c] = 0;
            m_tel[1][c] = 1'b0;
        end
        send_frame(1, 1, 16'h830B);
        check_val("b_after_rst_1000", longint'(speed_b[10:0]), 1000);
        send_frame(1, 0, 16'hFFEE);
        check_val("b_after_rst_1999", longint'(speed_b[21:11]), 1999);

        idle(20);
        check_val("queue_a_drained", q_a.size(), 0);
        check_val("queue_b_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
